// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry saturating counters, EX-stage misprediction detection
// and branch/mispredict statistics.
module branch_predict_unit #(
   parameter int unsigned ENTRIES  = 16,
   parameter int unsigned CTR_BITS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [31:0] lookup_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = 30 - IDX_W;

   localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
   localparam logic [CTR_BITS-1:0] CTR_WT   = {1'b1, {(CTR_BITS-1){1'b0}}};
   localparam logic [CTR_BITS-1:0] CTR_WNT  = {1'b0, {(CTR_BITS-1){1'b1}}};

   logic                valid_q  [ENTRIES];
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   logic [31:0]         target_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
   logic [31:0]         branch_count_q;
   logic [31:0]         mispredict_count_q;

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;

   always_comb begin
      lk_idx      = lookup_pc[IDX_W+1:2];
      lk_tag      = lookup_pc[31:IDX_W+2];
      lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
      pred_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
      pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + 32'd4;
   end

   always_comb begin
      ex_idx      = ex_pc[IDX_W+1:2];
      ex_tag      = ex_pc[31:IDX_W+2];
      ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      mispredict  = ex_valid && ((ex_pred_taken != ex_taken) ||
                                 (ex_taken && (ex_pred_target != ex_target)));
      redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_WNT;
         end
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         // Statistics keep counting even while the table is being cleared.
         if (ex_valid) begin
            if (branch_count_q != 32'hFFFF_FFFF) branch_count_q <= branch_count_q + 32'd1;
            if (mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
               mispredict_count_q <= mispredict_count_q + 32'd1;
            end
         end
         if (clear) begin
            for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
         end else if (ex_valid) begin
            if (ex_hit) begin
               if (ex_taken) begin
                  target_q[ex_idx] <= ex_target;
                  if (ctr_q[ex_idx] != CTR_MAX) ctr_q[ex_idx] <= ctr_q[ex_idx] + 1'b1;
               end else if (ctr_q[ex_idx] != CTR_ZERO) begin
                  ctr_q[ex_idx] <= ctr_q[ex_idx] - 1'b1;
               end
            end else if (ex_taken) begin
               valid_q[ex_idx]  <= 1'b1;
               tag_q[ex_idx]    <= ex_tag;
               target_q[ex_idx] <= ex_target;
               ctr_q[ex_idx]    <= CTR_WT;
            end
         end
      end
   end

   assign branch_count     = branch_count_q;
   assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench for branch_predict_unit (ENTRIES=16, CTR_BITS=2).
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        reset, clear, ex_valid, ex_taken, ex_pred_taken;
   logic [31:0] lookup_pc, ex_pc, ex_target, ex_pred_target;
   logic        pred_taken, mispredict;
   logic [31:0] pred_target, redirect_pc, branch_count, mispredict_count;

   always #5 clk = ~clk;

   branch_predict_unit #(.ENTRIES(16), .CTR_BITS(2)) dut (
      .clk              (clk),
      .reset            (reset),
      .clear            (clear),
      .lookup_pc        (lookup_pc),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .ex_valid         (ex_valid),
      .ex_pc            (ex_pc),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .mispredict       (mispredict),
      .redirect_pc      (redirect_pc),
      .branch_count     (branch_count),
      .mispredict_count (mispredict_count)
   );

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t        sb[$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int unsigned bc       = 0;
   int unsigned mc       = 0;

   localparam logic [31:0] PC_A = 32'h0040_0010;

   task automatic expect_val(input string tag, input logic [31:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic check_val(input logic [31:0] obs);
      exp_t e;
      n_assert++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid = 1'b0;
      clear    = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc, input logic ep, input logic [31:0] et,
                         input string tag);
      lookup_pc = pc;
      #1;
      expect_val({tag, "_taken"}, {31'b0, ep});
      check_val({31'b0, pred_taken});
      expect_val({tag, "_target"}, et);
      check_val(pred_target);
   endtask

   task automatic lookup_miss(input logic [31:0] pc, input string tag);
      lookup(pc, 1'b0, pc + 32'd4, tag);
   endtask

   task automatic counts(input string tag);
      expect_val({tag, "_branch_count"}, bc);
      check_val(branch_count);
      expect_val({tag, "_mispredict_count"}, mc);
      check_val(mispredict_count);
   endtask

   // Drives a resolving branch and checks the combinational EX outputs; caller clocks it.
   task automatic resolve(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                          input logic pt, input logic [31:0] ptgt, input string tag);
      logic exp_mis;
      ex_valid       = 1'b1;
      ex_pc          = pc;
      ex_taken       = t;
      ex_target      = tgt;
      ex_pred_taken  = pt;
      ex_pred_target = ptgt;
      #1;
      exp_mis = (pt != t) || (t && (ptgt != tgt));
      expect_val({tag, "_mispredict"}, {31'b0, exp_mis});
      check_val({31'b0, mispredict});
      expect_val({tag, "_redirect"}, t ? tgt : pc + 32'd4);
      check_val(redirect_pc);
      if (bc != 32'hFFFF_FFFF) bc++;
      if (exp_mis && mc != 32'hFFFF_FFFF) mc++;
   endtask

   initial begin
      logic        hy_t [10];
      logic        hy_p [10];
      logic        cur_p;

      reset = 1'b1; clear = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0;
      ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0; lookup_pc = '0;
      cycle();
      cycle();
      reset = 1'b0;

      // Cold state
      lookup_miss(PC_A, "cold");
      lookup(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "wrap");
      counts("reset");

      // Allocation; same-cycle lookup still sees the old contents
      resolve(PC_A, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014, "alloc");
      lookup_miss(PC_A, "alloc_same_cycle");
      cycle();
      idle();
      lookup(PC_A, 1'b1, 32'h0040_0100, "alloc_hit");
      counts("alloc");

      // Hysteresis from weakly taken: covers both saturation ends
      hy_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      hy_p = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      cur_p = 1'b1;
      for (int i = 0; i < 10; i++) begin
         resolve(PC_A, hy_t[i], 32'h0040_0100, cur_p,
                 cur_p ? 32'h0040_0100 : 32'h0040_0014, $sformatf("hyst%0d", i));
         cycle();
         idle();
         lookup(PC_A, hy_p[i], hy_p[i] ? 32'h0040_0100 : 32'h0040_0014,
                $sformatf("hyst%0d", i));
         cur_p = hy_p[i];
      end
      counts("hyst");

      // Wrong target on a hit
      resolve(PC_A, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100, "wrong_tgt");
      cycle();
      idle();
      lookup(PC_A, 1'b1, 32'h0000_0200, "wrong_tgt");

      resolve(PC_A, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0200, "correct");
      cycle();
      idle();

      // No valid branch: no mispredict, redirect still tracks ex_pc, counters hold
      ex_pc = 32'h0040_0070; ex_taken = 1'b0; ex_pred_taken = 1'b1;
      #1;
      expect_val("novalid_mispredict", 32'd0);
      check_val({31'b0, mispredict});
      expect_val("novalid_redirect", 32'h0040_0074);
      check_val(redirect_pc);
      cycle();
      counts("novalid");

      // Alias on the same index replaces the entry; pc[1:0] ignored
      resolve(32'h0040_0050, 1'b1, 32'h0040_0300, 1'b0, 32'h0040_0054, "alias");
      cycle();
      idle();
      lookup_miss(PC_A, "alias_old");
      lookup(32'h0040_0053, 1'b1, 32'h0040_0300, "alias_lowbits");

      // Not-taken miss must not allocate
      resolve(32'h0040_0080, 1'b0, 32'h0040_0500, 1'b0, 32'h0040_0084, "nt_miss");
      cycle();
      idle();
      lookup_miss(32'h0040_0080, "nt_miss");
      counts("pre_clear");

      // Clear racing an allocating update
      clear = 1'b1;
      resolve(32'h0040_0020, 1'b1, 32'h0040_0400, 1'b0, 32'h0040_0024, "clr_upd");
      cycle();
      idle();
      lookup_miss(32'h0040_0020, "clear_new");
      lookup_miss(32'h0040_0050, "clear_old");
      counts("clear");

      // Reset mid-stream wins over a concurrent update
      resolve(32'h0040_0030, 1'b1, 32'h0040_0600, 1'b0, 32'h0040_0034, "pre_rst");
      cycle();
      idle();
      lookup(32'h0040_0030, 1'b1, 32'h0040_0600, "pre_rst");
      reset = 1'b1;
      resolve(32'h0040_0040, 1'b1, 32'h0040_0700, 1'b0, 32'h0040_0044, "rst_upd");
      cycle();
      reset = 1'b0;
      bc = 0;
      mc = 0;
      idle();
      lookup_miss(32'h0040_0030, "rst_old");
      lookup_miss(32'h0040_0040, "rst_new");
      counts("reset_mid");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
